// File: rtl/usr_xfer_pkg.sv
// Shared types and constants for the universal shift register transfer controller.
package usr_xfer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    localparam logic OP_TX = 1'b0;
    localparam logic OP_RX = 1'b1;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

endpackage

// File: rtl/usr_xfer_ctrl_if.sv
// Command and response valid/ready bundle between a parallel producer/consumer and the controller.
interface usr_xfer_ctrl_if #(
    parameter int WIDTH = 4
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_op;
    logic             cmd_dir;
    logic [WIDTH-1:0] cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_dir, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_dir, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/usr_xfer_ctrl_core.sv
// WIDTH-bit universal shift register: hold, shift right, shift left or parallel load.
module usr_core
    import usr_xfer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] d_in,
    input  logic             fill,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    // Register update selected by the mode code
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            case (sel)
                SEL_HOLD: q_q <= q_q;
                SEL_SHR:  q_q <= {fill, q_q[WIDTH-1:1]};
                SEL_SHL:  q_q <= {q_q[WIDTH-2:0], fill};
                SEL_LOAD: q_q <= d_in;
                default:  q_q <= q_q;
            endcase
        end
    end

    assign q = q_q;

endmodule

// File: rtl/usr_xfer_ctrl.sv
// Transfer controller sequencing usr_core for TX (parallel-to-serial) and RX (serial-to-parallel).
// Optional feature: define USR_XFER_CTRL_ABORT_EN to add an abort input that cancels a transfer mid-shift.
module usr_xfer_ctrl
    import usr_xfer_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    usr_xfer_ctrl_if.slave bus,
    output logic           ser_en,
    output logic           ser_out,
    input  logic           ser_in,
    output logic [1:0]     usr_sel,
    output logic           busy
`ifdef USR_XFER_CTRL_ABORT_EN
    ,
    input  logic           abort
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic             op_q, op_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]       sel_s;
    logic [1:0]       core_sel_s;
    logic [WIDTH-1:0] load_data_s;
    logic             fill_s;
    logic [WIDTH-1:0] q_s;

    usr_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk  (clk),
        .rst  (rst),
        .sel  (core_sel_s),
        .d_in (load_data_s),
        .fill (fill_s),
        .q    (q_s)
    );

    // FSM and transfer context registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and datapath control
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        dir_d       = dir_q;
        cnt_d       = cnt_q;
        sel_s       = SEL_HOLD;
        core_sel_s  = SEL_HOLD;
        load_data_s = '0;
        fill_s      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    op_d        = bus.cmd_op;
                    dir_d       = bus.cmd_dir;
                    cnt_d       = '0;
                    sel_s       = SEL_LOAD;
                    core_sel_s  = SEL_LOAD;
                    load_data_s = (bus.cmd_op == OP_TX) ? bus.cmd_data : '0;
                    state_d     = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                sel_s      = dir_q ? SEL_SHL : SEL_SHR;
                core_sel_s = sel_s;
                fill_s     = (op_q == OP_RX) ? ser_in : 1'b0;
                cnt_d      = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
`ifdef USR_XFER_CTRL_ABORT_EN
                // Abort reuses the load path with zero data to clear the register
                if (abort) begin
                    core_sel_s  = SEL_LOAD;
                    load_data_s = '0;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end else begin
                    core_sel_s = sel_s;
                end
`endif
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode; everything is forced quiet while reset is held
    always_comb begin
        bus.cmd_ready = !rst && (state_q == IDLE);
        bus.rsp_valid = !rst && (state_q == DONE);
        bus.rsp_data  = rst ? '0 : q_s;
        ser_en        = !rst && (state_q == SHIFT);
        busy          = !rst && (state_q != IDLE);
        usr_sel       = rst ? SEL_HOLD : sel_s;
        if (ser_en) begin
            ser_out = dir_q ? q_s[WIDTH-1] : q_s[0];
        end else begin
            ser_out = 1'b0;
        end
    end

endmodule

// File: tb/tb_usr_xfer_ctrl.sv
// Randomised self-checking bench for usr_xfer_ctrl against a word-level transfer model.
module tb_usr_xfer_ctrl;
    import usr_xfer_pkg::*;

    localparam int W = 4;

    logic       clk;
    logic       rst;
    logic       ser_en;
    logic       ser_out;
    logic       ser_in;
    logic [1:0] usr_sel;
    logic       busy;
`ifdef USR_XFER_CTRL_ABORT_EN
    logic       abort;
`endif

    usr_xfer_ctrl_if #(.WIDTH(W)) bus ();

    usr_xfer_ctrl #(
        .WIDTH (W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .ser_en  (ser_en),
        .ser_out (ser_out),
        .ser_in  (ser_in),
        .usr_sel (usr_sel),
        .busy    (busy)
`ifdef USR_XFER_CTRL_ABORT_EN
        ,
        .abort   (abort)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic         cur_op;
    logic         cur_dir;
    logic [W-1:0] cur_data;
    logic [W-1:0] cur_rx;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: TX sends the word LSB-first (dir=0) or MSB-first (dir=1)
    function automatic logic tx_bit(input int i);
        return cur_dir ? cur_data[W-1-i] : cur_data[i];
    endfunction

    // Model: RX places the first received bit furthest from the entry end
    function automatic logic [W-1:0] expected_word();
        logic [W-1:0] w;
        w = '0;
        if (cur_op == OP_RX) begin
            for (int i = 0; i < W; i++) begin
                if (cur_dir) w[W-1-i] = cur_rx[i];
                else         w[i]     = cur_rx[i];
            end
        end
        return w;
    endfunction

    task automatic accept(input logic op, input logic dir, input logic [W-1:0] data,
                          input logic [W-1:0] rx);
        cur_op   = op;
        cur_dir  = dir;
        cur_data = data;
        cur_rx   = rx;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_dir   = dir;
        bus.cmd_data  = data;
        bus.rsp_ready = 1'b0;
        #1;
        check_eq("acc_ready", bus.cmd_ready, 1'b1);
        check_eq("acc_sel", usr_sel, SEL_LOAD);
        check_eq("acc_busy", busy, 1'b0);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = $urandom();
    endtask

    task automatic shift(input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            ser_in = cur_rx[i];
            #1;
            check_eq("sh_en", ser_en, 1'b1);
            check_eq("sh_sel", usr_sel, cur_dir ? SEL_SHL : SEL_SHR);
            check_eq("sh_ready", bus.cmd_ready, 1'b0);
            check_eq("sh_rspv", bus.rsp_valid, 1'b0);
            if (cur_op == OP_TX) check_eq("ser_out", ser_out, tx_bit(i));
            @(negedge clk);
        end
        ser_in = 1'b0;
    endtask

    task automatic respond(input int stall);
        logic [W-1:0] exp;
        exp = expected_word();
        for (int k = 0; k < stall; k++) begin
            bus.cmd_valid = 1'b1;
            bus.rsp_ready = 1'b0;
            #1;
            check_eq("bp_valid", bus.rsp_valid, 1'b1);
            check_eq("bp_data", bus.rsp_data, exp);
            check_eq("bp_ready", bus.cmd_ready, 1'b0);
            check_eq("bp_sel", usr_sel, SEL_HOLD);
            @(negedge clk);
        end
        bus.cmd_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        #1;
        check_eq("rsp_valid", bus.rsp_valid, 1'b1);
        check_eq("rsp_data", bus.rsp_data, exp);
        check_eq("done_ready", bus.cmd_ready, 1'b0);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        #1;
        check_eq("idle_busy", busy, 1'b0);
        check_eq("idle_en", ser_en, 1'b0);
        check_eq("idle_rspv", bus.rsp_valid, 1'b0);
    endtask

    task automatic xfer(input logic op, input logic dir, input logic [W-1:0] data,
                        input logic [W-1:0] rx, input int stall);
        accept(op, dir, data, rx);
        shift(0, W);
        respond(stall);
    endtask

    initial begin
        clk           = 1'b0;
        rst           = 1'b1;
        ser_in        = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'b0;
        bus.cmd_dir   = 1'b0;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b0;
`ifdef USR_XFER_CTRL_ABORT_EN
        abort         = 1'b0;
`endif
        repeat (2) @(negedge clk);
        bus.cmd_valid = 1'b1;
        #1;
        check_eq("rst_ready", bus.cmd_ready, 1'b0);
        check_eq("rst_sel", usr_sel, SEL_HOLD);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_rspv", bus.rsp_valid, 1'b0);
        check_eq("rst_data", bus.rsp_data, 0);
        bus.cmd_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Directed cases from the worked examples
        xfer(OP_TX, 1'b0, 4'b1011, 4'b0000, 0);
        xfer(OP_TX, 1'b1, 4'b1011, 4'b0000, 0);
        xfer(OP_RX, 1'b1, 4'b0000, 4'b0011, 0);
        xfer(OP_RX, 1'b0, 4'b1111, 4'b0011, 3);

        // Reset in the middle of a TX
        accept(OP_TX, 1'b0, 4'b1011, 4'b0000);
        shift(0, 2);
        rst = 1'b1;
        #1;
        check_eq("mrst_en", ser_en, 1'b0);
        check_eq("mrst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("mrst_idle", busy, 1'b0);
        check_eq("mrst_ready", bus.cmd_ready, 1'b1);
        check_eq("mrst_rspv", bus.rsp_valid, 1'b0);
        check_eq("mrst_data", bus.rsp_data, 0);
        xfer(OP_TX, 1'b0, 4'b0110, 4'b0000, 0);

`ifdef USR_XFER_CTRL_ABORT_EN
        accept(OP_RX, 1'b1, 4'b0000, 4'b1111);
        shift(0, 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        check_eq("ab_busy", busy, 1'b0);
        check_eq("ab_rspv", bus.rsp_valid, 1'b0);
        check_eq("ab_ready", bus.cmd_ready, 1'b1);
        check_eq("ab_data", bus.rsp_data, 0);
`endif

        // Randomised transfers with random response backpressure
        for (int t = 0; t < 24; t++) begin
            xfer(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                 W'($urandom()), W'($urandom()), int'($urandom_range(3, 0)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/usr_xfer_ctrl.md
# usr_xfer_ctrl

Transfer controller that owns a WIDTH-bit universal shift register and sequences it for parallel-to-serial (TX) and serial-to-parallel (RX) transfers. Commands arrive on a valid/ready port. The controller loads, shifts WIDTH times in the requested direction, and returns the resulting word on a valid/ready response port. It sits between a parallel producer/consumer and a single-wire serial link.

## Interface
- WIDTH, 4: shift register width in bits, ≥2.
- CNT_W, $clog2(WIDTH+1): shift counter width, derived; never overridden.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  controller can accept a command
- cmd_op  input  1  0=TX, 1=RX
- cmd_dir  input  1  0=shift right (exit q[0], entry q[WIDTH-1]), 1=shift left (exit q[WIDTH-1], entry q[0])
- cmd_data  input  WIDTH  TX word; ignored for RX
- ser_en  output  1  shift cycle active
- ser_out  output  1  TX bit, valid when ser_en && op==TX
- ser_in  input  1  RX bit, sampled at the rising edge ending each ser_en cycle
- rsp_valid  output  1  result word available
- rsp_ready  input  1  consumer accepts result
- rsp_data  output  WIDTH  register contents
- usr_sel  output  2  current register mode (00 hold, 01 shift right, 10 shift left, 11 load)
- busy  output  1  state != IDLE

## Operation
- Reset (rst high at an edge): state=IDLE, register=0, counter=0, latched op/dir=0. While rst is high, cmd_ready=0 and all other outputs are 0.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch op and dir. The register loads cmd_data for TX and 0 for RX; usr_sel=11 in this cycle. Counter=0. Next state is SHIFT.
  - SHIFT: ser_en=1, usr_sel=01/10 per dir. Every edge shifts the register one position.
    - TX: fill bit is 0; ser_out is the exit bit before the shift.
    - RX: the fill bit is ser_in.
    - Counter increments each edge. The edge where the counter reaches WIDTH moves the FSM to DONE.
  - DONE: rsp_valid=1, rsp_data=register, usr_sel=00. On rsp_valid&&rsp_ready, go to IDLE.
    - TX result is always 0 (zero fill).
    - RX result is the captured word.
- cmd_ready=0 in SHIFT and DONE. Commands offered then are not accepted and stay pending at the source.
- A rsp_ready asserted before rsp_valid has no effect.
- rsp_data and rsp_valid hold stable under backpressure.
- rst asserted in any state overrides everything. At the next edge the controller is in IDLE with the register cleared and no response issued.

## Timing
- Command accepted at edge E0. SHIFT occupies cycles E0..E0+WIDTH-1. rsp_valid rises after edge E0+WIDTH.
- Minimum command-to-command spacing is WIDTH+2 cycles: accept, WIDTH shifts, one DONE cycle with rsp_ready=1.
- In DONE, a response handshake and a pending cmd_valid in the same cycle do not accept the command. The earliest accept is the following IDLE cycle.
- cmd_ready, ser_en, ser_out, rsp_valid, usr_sel and busy decode combinationally from state and registers. None of them depends combinationally on cmd_valid or rsp_ready, except usr_sel=11 in the accept cycle.

## Configuration
- USR_XFER_CTRL_ABORT_EN defined:
  - Adds input port abort (1 bit).
  - abort high at an edge while in SHIFT clears the register and counter and moves to IDLE. No response is issued.
  - abort is ignored in IDLE and DONE.
  - rst has priority over abort.
- Macro undefined: the port is absent and a transfer always runs to completion.

## Structure
- Package usr_xfer_pkg holds:
  - state enum: IDLE, SHIFT, DONE.
  - op constants: OP_TX=0, OP_RX=1.
  - sel constants: SEL_HOLD=2'b00, SEL_SHR=2'b01, SEL_SHL=2'b10, SEL_LOAD=2'b11.
- Sub-module usr_core is the shift register datapath, instantiated once and driven by the controller's usr_sel, load data and fill bit.
  - Parameterised by WIDTH; synchronous active-high reset.
  - Inputs: sel, d_in, fill bit. Output: q.

## Test plan
- TX, dir=0, cmd_data=4'b1011 → ser_out 1,1,0,1 on 4 consecutive ser_en cycles; rsp_valid on the 5th cycle after accept; rsp_data=4'b0000.
- TX, dir=1, cmd_data=4'b1011 → ser_out 1,0,1,1.
- RX with ser_in stream 1,1,0,0: dir=1 → rsp_data=4'b1100; dir=0 → rsp_data=4'b0011.
- Hold rsp_ready low 3 cycles in DONE with cmd_valid high → rsp_valid/rsp_data stable, cmd_ready=0; raise rsp_ready → IDLE next cycle, command accepted the cycle after.
- rst pulsed for 1 cycle after 2 TX shifts → next cycle IDLE, ser_en=0, rsp_valid=0, rsp_data=0. A fresh TX of 4'b0110 then produces ser_out 0,1,1,0 (dir=0).
- With USR_XFER_CTRL_ABORT_EN: abort after 2 RX shifts → IDLE next cycle, no rsp_valid, cmd_ready=1.
